rom_string_uart_tx: RTL and testbench

- Reader side of the character ROMs: walks a 4-bit-addressed, 8-bit-data character ROM from address 0 and streams each character out as 8N1 UART serial.
- Stops at the first NUL (0x00) or after the last address.
- Sits between a character ROM (combinational read) and the board TX pin. Triggered by a one-cycle start pulse; reports busy, done and the number of characters sent.

---
 rtl/rom_string_uart_tx_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/rom_string_uart_tx.sv | 122 ++++++++++++
 tb/tb_rom_string_uart_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_string_uart_tx_pkg.sv
// Shared types and constants for the ROM-string UART transmitter.
package rom_string_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    localparam logic [7:0] NUL_CHAR       = 8'h00;
    localparam logic       TX_IDLE        = 1'b1;
    localparam int         UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_end marks the last clock of each UART bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/rom_string_uart_tx.sv
// Walks a character ROM from address 0 and sends each byte as 8N1 UART,
// stopping at the first NUL or after MAX_LEN characters.
module rom_string_uart_tx
    import rom_string_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_LEN      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   char_count
);

    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              baud_clr;
    logic              bit_end;

    // The counter only runs in the timed states, so it starts from zero on
    // entry to START_BIT and wraps naturally across the later bit boundaries.
    assign baud_clr = (state == IDLE) || (state == FETCH) || (state == DONE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (baud_clr),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            shreg <= rom_data;
        end else if (bit_end && (state == START_BIT || state == DATA_BITS)) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= TX_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rom_addr   <= '0;
            char_count <= '0;
            bit_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= TX_IDLE;
                    // A start coinciding with the done pulse is not a new request.
                    if (start && !done) begin
                        state      <= FETCH;
                        rom_addr   <= '0;
                        char_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    bit_idx <= '0;
                    if (rom_data == NUL_CHAR) begin
                        state <= DONE;
                    end else begin
                        state <= START_BIT;
                        tx    <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        state <= DATA_BITS;
                        tx    <= shreg[0];
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP_BIT;
                            tx    <= TX_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                        end
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        char_count <= char_count + 1'b1;
                        // Length check precedes the increment so the address never wraps.
                        if (char_count + 1'b1 == MAX_CNT) begin
                            state <= DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_string_uart_tx.sv
// Directed bench for rom_string_uart_tx with a combinational ROM model and
// a cycle-counting UART frame decoder.
module tb_rom_string_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] char_count;

    logic [7:0] rom [16];
    assign rom_data = rom[rom_addr];

    int total = 0;
    int bad   = 0;

    rom_string_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (4),
        .DATA_W      (8),
        .MAX_LEN     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .char_count(char_count)
    );

    always #5 clk = ~clk;

    // Frame decoder and event counters, sampled on the falling edge.
    logic       mon_clr = 1'b0;
    int         frames, done_cnt, busy_cyc, tx_low_cyc, bad_stop, ph;
    logic [7:0] sh;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (mon_clr) begin
            frames = 0; done_cnt = 0; busy_cyc = 0; tx_low_cyc = 0;
            bad_stop = 0; ph = -1; rx_q.delete();
        end else begin
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (!tx)  tx_low_cyc++;
            if (ph < 0) begin
                if (!tx) ph = 0;
            end else begin
                ph++;
                if ((ph % CPB) == CPB / 2 && ph / CPB >= 1 && ph / CPB <= 8)
                    sh[ph / CPB - 1] = tx;
                if (ph == 9 * CPB + CPB / 2) begin
                    frames++;
                    if (tx) rx_q.push_back(sh);
                    else    bad_stop++;
                end
                if (ph == 10 * CPB - 1) ph = -1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick(1);
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (!done && n < 2000) begin
            tick(1);
            n++;
        end
        check_eq(tag, n, exp_cycles);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < 16; i++) begin
            if (i < s.len())       rom[i] = s[i];
            else if (i == s.len()) rom[i] = 8'h00;
            else                   rom[i] = 8'h5A;
        end
    endtask

    task automatic check_msg(input string tag, input string s);
        int m;
        check_eq({tag, "_frames"}, frames, s.len());
        check_eq({tag, "_stop"}, bad_stop, 0);
        m = (rx_q.size() < s.len()) ? rx_q.size() : s.len();
        for (int i = 0; i < m; i++) check_eq({tag, "_char"}, rx_q[i], s[i]);
    endtask

    initial begin
        load_str("STUDENT");
        tick(3);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_addr", rom_addr, 0);
        check_eq("rst_cnt", char_count, 0);
        rst = 1'b0;
        clear_mon();

        // "STUDENT" with NUL at address 7
        pulse_start();
        check_eq("fetch_tx", tx, 1);
        check_eq("fetch_busy", busy, 1);
        tick(1);
        check_eq("startbit_tx", tx, 0);
        wait_done("student_lat", 288);
        check_eq("student_cnt", char_count, 7);
        check_eq("student_addr", rom_addr, 7);
        check_eq("student_busy_end", busy, 0);
        tick(1);
        check_eq("done_width", done, 0);
        check_eq("student_busycyc", busy_cyc, 7 * 41 + 2);
        check_eq("student_donecnt", done_cnt, 1);
        check_eq("first_char", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h53);
        check_msg("student", "STUDENT");

        // No NUL anywhere: limited by MAX_LEN
        for (int i = 0; i < 16; i++) rom[i] = 8'h41;
        clear_mon();
        pulse_start();
        wait_done("full_lat", 657);
        check_eq("full_cnt", char_count, 16);
        check_eq("full_addr", rom_addr, 15);
        tick(2);
        check_eq("full_busycyc", busy_cyc, 657);
        check_msg("full", "AAAAAAAAAAAAAAAA");

        // Empty message
        rom[0] = 8'h00;
        clear_mon();
        pulse_start();
        wait_done("empty_lat", 2);
        check_eq("empty_cnt", char_count, 0);
        check_eq("empty_addr", rom_addr, 0);
        tick(2);
        check_eq("empty_txlow", tx_low_cyc, 0);
        check_eq("empty_donecnt", done_cnt, 1);

        // Reset during data bit 3 of 'T' (0x54, bit 3 = 0)
        load_str("STUDENT");
        clear_mon();
        pulse_start();
        tick(58);
        check_eq("b3_tx", tx, 0);
        check_eq("b3_cnt", char_count, 1);
        check_eq("b3_addr", rom_addr, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("mrst_tx", tx, 1);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_addr", rom_addr, 0);
        check_eq("mrst_cnt", char_count, 0);
        check_eq("mrst_done", done, 0);
        tick(50);
        check_eq("mrst_nodone", done_cnt, 0);
        check_eq("mrst_idle_tx", tx, 1);
        clear_mon();
        pulse_start();
        tick(1);
        wait_done("rerun_lat", 288);
        check_eq("rerun_cnt", char_count, 7);
        tick(1);
        check_msg("rerun", "STUDENT");

        // Starts while busy and in the done cycle are ignored
        clear_mon();
        pulse_start();
        tick(100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("busy_start_lat", 188);
        check_eq("busy_start_cnt", char_count, 7);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check_eq("donecyc_start_busy", busy, 0);
        check_eq("busy_start_busycyc", busy_cyc, 289);
        check_msg("busy_start", "STUDENT");
        pulse_start();
        check_eq("after_done_busy", busy, 1);
        check_eq("after_done_cnt", char_count, 0);
        wait_done("after_done_lat", 289);
        check_eq("after_done_final", char_count, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
